// File: rtl/ped_request_ctrl_if.sv
// Signal bundle between the pedestrian request controller and its surroundings:
// button, 1 Hz level and phase in; change pulse, pending flag and debounced level out.
interface ped_request_ctrl_if;
  logic btn_raw;
  logic sec_clk;
  logic walk;
  logic change_state;
  logic req_pending;
  logic btn_level;

  modport master (
    output btn_raw,
    output sec_clk,
    output walk,
    input  change_state,
    input  req_pending,
    input  btn_level
  );

  modport slave (
    input  btn_raw,
    input  sec_clk,
    input  walk,
    output change_state,
    output req_pending,
    output btn_level
  );
endinterface

// File: rtl/ped_request_ctrl.sv
// Pedestrian request controller: synchronises and debounces the crossing button, holds the
// request for a minimum number of 1 Hz ticks, then emits a one-cycle change_state pulse.
module ped_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MIN_WAIT        = 5
) (
  input logic               clk,
  input logic               rst,
  ped_request_ctrl_if.slave req_if
);

  localparam int unsigned DbClog = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned DbW    = (DbClog > 19) ? DbClog : 19;
  localparam logic [DbW-1:0] DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]     MinWaitVal = 4'(MIN_WAIT);

  typedef enum logic [1:0] {StIdle, StWait, StFire, StServed} state_e;

  logic           btn_meta_q, btn_s_q;
  logic           sec_meta_q, sec_s_q, sec_d_q;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           btn_level_q, btn_level_d, btn_level_dly_q;
  state_e         state_q, state_d;
  logic [3:0]     wait_cnt_q, wait_cnt_d;
  logic [1:0]     guard_cnt_q, guard_cnt_d;
  logic           req_pending_q, req_pending_d;
  logic           change_state_q;
  logic           press, tick;

  // Two-flop synchronisers plus the delay flops used for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_q      <= 1'b0;
      btn_s_q         <= 1'b0;
      sec_meta_q      <= 1'b0;
      sec_s_q         <= 1'b0;
      sec_d_q         <= 1'b0;
      btn_level_dly_q <= 1'b0;
    end else begin
      btn_meta_q      <= req_if.btn_raw;
      btn_s_q         <= btn_meta_q;
      sec_meta_q      <= req_if.sec_clk;
      sec_s_q         <= sec_meta_q;
      sec_d_q         <= sec_s_q;
      btn_level_dly_q <= btn_level_q;
    end
  end

  assign press = btn_level_q & ~btn_level_dly_q;
  assign tick  = sec_s_q & ~sec_d_q;

  // Any reversal of btn_s back to the accepted level restarts the stability count.
  always_comb begin
    db_cnt_d    = db_cnt_q;
    btn_level_d = btn_level_q;
    if (btn_s_q == btn_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DbLast) begin
      db_cnt_d    = '0;
      btn_level_d = btn_s_q;
    end else begin
      db_cnt_d = db_cnt_q + DbW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q    <= '0;
      btn_level_q <= 1'b0;
    end else begin
      db_cnt_q    <= db_cnt_d;
      btn_level_q <= btn_level_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    guard_cnt_d   = guard_cnt_q;
    req_pending_d = req_pending_q;
    unique case (state_q)
      StIdle: begin
        if (press && !req_if.walk) begin
          state_d       = StWait;
          wait_cnt_d    = MinWaitVal;
          req_pending_d = 1'b1;
        end
      end
      StWait: begin
        // A walk phase arriving on its own serves the request; it outranks the countdown.
        if (req_if.walk) begin
          state_d       = StIdle;
          req_pending_d = 1'b0;
        end else if (wait_cnt_q == 4'd0) begin
          state_d = StFire;
        end else if (tick) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      StFire: begin
        state_d     = StServed;
        guard_cnt_d = 2'd0;
      end
      StServed: begin
        if (req_if.walk) begin
          state_d       = StIdle;
          req_pending_d = 1'b0;
        end else if (tick) begin
          guard_cnt_d = guard_cnt_q + 2'd1;
          // Two ticks without a walk phase means the counter ignored the pulse.
          if (guard_cnt_q == 2'd1) begin
            state_d       = StIdle;
            req_pending_d = 1'b0;
          end
        end
      end
      default: begin
        state_d       = StIdle;
        req_pending_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      wait_cnt_q     <= 4'd0;
      guard_cnt_q    <= 2'd0;
      req_pending_q  <= 1'b0;
      change_state_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      guard_cnt_q    <= guard_cnt_d;
      req_pending_q  <= req_pending_d;
      change_state_q <= (state_d == StFire);
    end
  end

  assign req_if.change_state = change_state_q;
  assign req_if.req_pending  = req_pending_q;
  assign req_if.btn_level    = btn_level_q;

  a_pulse_single: assert property (@(posedge clk) disable iff (rst)
    change_state_q |=> !change_state_q);
  a_pulse_needs_req: assert property (@(posedge clk) disable iff (rst)
    change_state_q |-> req_pending_q);

endmodule
